// File: rtl/pid_pwm_pkg.sv
// Shared types and the load-time conversion for pid_pwm: fixed-point PID output to a clamped PWM duty.
package PidPwmPkg;

  localparam int DUTY_W = 16;

  typedef logic [DUTY_W-1:0] count_t;

  typedef struct packed {
    logic   sat;
    count_t value;
  } clamp_t;

  // Clamping happens on the full-width signed integer part; only the in-range result is narrowed.
  function automatic clamp_t clamp_duty(input logic signed [63:0] in, input int fw, input int period);
    logic signed [63:0] q;
    clamp_t r;
    q = in >>> fw;
    r.sat = 1'b1;
    if (q < 64'sd0)
      r.value = '0;
    else if (q > 64'(period))
      r.value = count_t'(period);
    else begin
      r.value = count_t'(q);
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pid_pwm_deadtime.sv
// Rising-edge delay for one PWM leg: output rises DT clocks after the input, falls with it.
module pwm_deadtime #(
  parameter int DT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i,
  output logic o
);

  localparam int DW = (DT < 1) ? 1 : $clog2(DT + 1);

  logic [DW-1:0] wait_cnt;

  // Held at DT while the input is low, so every new pulse must survive DT clocks before showing.
  always_ff @(posedge clk) begin
    if (rst || !i)
      wait_cnt <= DW'(DT);
    else if (wait_cnt != '0)
      wait_cnt <= wait_cnt - DW'(1);
  end

  assign o = i && (wait_cnt == '0);

endmodule

// File: rtl/pid_pwm.sv
// Edge-aligned PWM stage and loop timebase for the PID controller, with double-buffered duty.
// Define PWM_DEADTIME_EN to add the complementary pwm_n output with DT-clock dead-time.
module pid_pwm
  import PidPwmPkg::*;
#(
  parameter int W      = 32,
  parameter int FW     = 16,
  parameter int PERIOD = 1000,
  parameter int CW     = 16,
  parameter int DIV    = 2
`ifdef PWM_DEADTIME_EN
  ,
  parameter int DT     = 4
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] in,
  input  logic                load,
  output logic                pwm,
`ifdef PWM_DEADTIME_EN
  output logic                pwm_n,
`endif
  output logic                sample,
  output logic                sat,
  output logic [CW-1:0]       duty
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] shadow;
  logic [CW-1:0] load_duty;
  logic [7:0]    per_cnt;
  logic          boundary;
  logic          last_div;
  logic          pwm_next;
  clamp_t        cl;

  always_comb begin
    cl        = clamp_duty(64'(in), FW, PERIOD);
    load_duty = CW'(cl.value);
  end

  assign boundary = (cnt == CW'(PERIOD - 1));
  assign last_div = (per_cnt == 8'(DIV - 1));
  assign pwm_next = (cnt < duty);

  // A load on the boundary cycle bypasses the shadow so it still lands in the next period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      per_cnt <= '0;
      shadow  <= '0;
      duty    <= '0;
      sample  <= 1'b0;
      sat     <= 1'b0;
    end else begin
      cnt    <= boundary ? '0 : cnt + CW'(1);
      sample <= boundary && last_div;
      if (boundary)
        per_cnt <= last_div ? '0 : per_cnt + 8'd1;
      if (load) begin
        shadow <= load_duty;
        sat    <= cl.sat;
      end
      if (boundary)
        duty <= load ? load_duty : shadow;
    end
  end

`ifdef PWM_DEADTIME_EN
  logic raw_hi;
  logic raw_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_hi <= 1'b0;
      raw_lo <= 1'b0;
    end else begin
      raw_hi <= pwm_next;
      raw_lo <= !pwm_next;
    end
  end

  pwm_deadtime #(.DT(DT)) u_dt_hi (.clk(clk), .rst(rst), .i(raw_hi), .o(pwm));
  pwm_deadtime #(.DT(DT)) u_dt_lo (.clk(clk), .rst(rst), .i(raw_lo), .o(pwm_n));
`else
  always_ff @(posedge clk) begin
    if (rst)
      pwm <= 1'b0;
    else
      pwm <= pwm_next;
  end
`endif

endmodule

// File: tb/tb_pid_pwm.sv
// Directed bench for pid_pwm at PERIOD=10, DIV=2, FW=16; phase tracks the expected counter value.
module tb_pid_pwm;

  localparam int P = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic               load;
  logic signed [31:0] din;
  logic               pwm;
  logic               sample;
  logic               sat;
  logic [15:0]        duty;
`ifdef PWM_DEADTIME_EN
  logic               pwm_n;
`endif

  int errors = 0;
  int checks = 0;
  int phase  = 0;
  int n;
  int h1;
  int h2;
  int lo;
  int both;

  always #5 clk = ~clk;

  pid_pwm #(
    .W(32), .FW(16), .PERIOD(P), .CW(16), .DIV(2)
`ifdef PWM_DEADTIME_EN
    , .DT(2)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(din),
    .load(load),
    .pwm(pwm),
`ifdef PWM_DEADTIME_EN
    .pwm_n(pwm_n),
`endif
    .sample(sample),
    .sat(sat),
    .duty(duty)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    phase = rst ? 0 : (phase + 1) % P;
  endtask

  task automatic alignTo(input int p);
    for (int k = 0; k < P && phase != p; k++) step();
  endtask

  task automatic applyStimulus(input logic [31:0] value);
    din  = value;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic measure(output int highs);
    highs = 0;
    repeat (P) begin
      step();
      if (pwm === 1'b1) highs++;
    end
  endtask

  task automatic waitSample(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (sample !== 1'b1 && cycles < 50);
  endtask

`ifdef PWM_DEADTIME_EN
  task automatic measureDt(output int hi, output int lo_cnt, output int both_cnt);
    hi = 0; lo_cnt = 0; both_cnt = 0;
    repeat (P) begin
      step();
      if (pwm === 1'b1) hi++;
      if (pwm_n === 1'b1) lo_cnt++;
      if (pwm === 1'b1 && pwm_n === 1'b1) both_cnt++;
    end
  endtask
`endif

  initial begin
    rst = 1'b1; load = 1'b0; din = '0;
    repeat (3) step();
    checkOutput("reset_pwm", 32'(pwm), 0);
    checkOutput("reset_sample", 32'(sample), 0);
    checkOutput("reset_sat", 32'(sat), 0);
    checkOutput("reset_duty", 32'(duty), 0);
    rst = 1'b0;
    waitSample(n);
    checkOutput("first_sample", n, 20);
    step();
    checkOutput("sample_width", 32'(sample), 0);

    alignTo(3);
    applyStimulus(32'h0003_8000);
    checkOutput("duty_held", 32'(duty), 0);
    checkOutput("sat_3p5", 32'(sat), 0);
    alignTo(0);
    checkOutput("duty_3", 32'(duty), 3);
    measure(h1);
    checkOutput("highs_3", h1, 3);

    alignTo(3);
    applyStimulus(32'hFFFF_0000);
    checkOutput("sat_neg", 32'(sat), 1);
    alignTo(0);
    checkOutput("duty_neg", 32'(duty), 0);
    measure(h1);
    checkOutput("highs_neg", h1, 0);

    alignTo(3);
    applyStimulus(32'h0019_0000);
    checkOutput("sat_big", 32'(sat), 1);
    alignTo(0);
    checkOutput("duty_big", 32'(duty), 10);
    measure(h1);
    measure(h2);
    checkOutput("const_high", h1 + h2, 20);

    alignTo(3);
    applyStimulus(32'h000A_0000);
    checkOutput("sat_exact_period", 32'(sat), 0);
    alignTo(0);
    checkOutput("duty_exact_period", 32'(duty), 10);

    // -0.5 truncates toward minus infinity to -1, so it saturates
    alignTo(3);
    applyStimulus(32'hFFFF_8000);
    checkOutput("sat_neg_half", 32'(sat), 1);
    alignTo(0);
    checkOutput("duty_neg_half", 32'(duty), 0);

    alignTo(9);
    applyStimulus(32'h0007_0000);
    checkOutput("duty_coincide", 32'(duty), 7);
    checkOutput("sat_coincide", 32'(sat), 0);
    measure(h1);
    checkOutput("highs_coincide", h1, 7);

    alignTo(2);
    applyStimulus(32'h0002_0000);
    step();
    applyStimulus(32'h0006_0000);
    alignTo(0);
    checkOutput("duty_last_wins", 32'(duty), 6);
    measure(h1);
    checkOutput("highs_last_wins", h1, 6);

    applyStimulus(32'h0005_0000);
    alignTo(0);
    alignTo(3);
    checkOutput("pwm_before_rst", 32'(pwm), 1);
    rst = 1'b1;
    step();
    checkOutput("pwm_after_rst", 32'(pwm), 0);
    checkOutput("duty_after_rst", 32'(duty), 0);
    step();
    rst = 1'b0;
    waitSample(n);
    checkOutput("sample_after_rst", n, 20);
    measure(h1);
    checkOutput("highs_after_rst", h1, 0);

`ifdef PWM_DEADTIME_EN
    applyStimulus(32'h0005_0000);
    alignTo(0);
    measureDt(h1, lo, both);
    measureDt(h1, lo, both);
    checkOutput("dt_hi_5", h1, 3);
    checkOutput("dt_lo_5", lo, 3);
    checkOutput("dt_overlap_5", both, 0);
    applyStimulus(32'h0001_0000);
    alignTo(0);
    measureDt(h1, lo, both);
    measureDt(h1, lo, both);
    checkOutput("dt_hi_1", h1, 0);
    checkOutput("dt_overlap_1", both, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
